agu_ctx_seq: RTL and testbench
==============================

AGU_CTX_SEQ -- requirements
Module: agu_ctx_seq

Interface
REQ-001 SHALL have parameter CTX_W, default 29: width of one AGU configuration word.
REQ-002 SHALL have parameter CTX_DEPTH, default 16: number of context slots (index width 4).
REQ-003 SHALL have port CLK, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port RST, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port cfg_we, input, 1: write strobe for the context store.
REQ-006 SHALL have port cfg_addr, input, 4: context slot to write.
REQ-007 SHALL have port cfg_wdata, input, CTX_W: context word to write.
REQ-008 SHALL have port start, input, 1: begin sequencing (level-sampled, acted on only in IDLE).
REQ-009 SHALL have port ctx_last, input, 4: index of last context in the program, sampled on start.
REQ-010 SHALL have port iter_last, input, 8: number of passes minus one, sampled on start.
REQ-011 SHALL have port stall, input, 1: AGU/memory not ready; hold current context.
REQ-012 SHALL have port abort, input, 1: terminate run immediately, no done.
REQ-013 SHALL have port ctx_word, output, CTX_W: word driven to the AGU decode stage.
REQ-014 SHALL have port ctx_valid, output, 1: ctx_word is a live context.
REQ-015 SHALL have port ctx_idx, output, 4: index of the context currently presented.
REQ-016 SHALL have port busy, output, 1: high in RUN and FIN.
REQ-017 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-018 SHALL have port cfg_err, output, 1: one-cycle pulse on a rejected write.

Function
REQ-019 SHALL implement states IDLE, RUN, FIN.
REQ-020 IDLE: cfg_we SHALL write cfg_wdata to slot cfg_addr, visible to a run starting the next cycle.
REQ-021 RUN or FIN: cfg_we SHALL be ignored (store unchanged) and cfg_err SHALL pulse the following cycle.
REQ-022 IDLE with start=1 SHALL latch ctx_last/iter_last, clear pc and iteration counter, and enter RUN; first context is presented the next cycle.
REQ-023 SHALL drive ctx_word = store[pc] and ctx_valid=1 in RUN; ctx_word=0 (opcode 0000, NOP) and ctx_valid=0 otherwise.
REQ-024 SHALL advance one context per cycle in RUN when stall=0; with stall=1, pc, iteration counter, ctx_word and ctx_idx SHALL hold.
REQ-025 At pc==ctx_last, not stalled, iter<iter_last: pc SHALL wrap to 0 and iteration counter SHALL increment by 1.
REQ-026 At pc==ctx_last, not stalled, iter==iter_last: SHALL enter FIN; done SHALL be 1 for exactly the FIN cycle; then IDLE.
REQ-027 ctx_last=0 SHALL present slot 0 once per pass; iter_last=255 SHALL yield 256 passes without counter overflow.
REQ-028 abort=1 in RUN or FIN SHALL return to IDLE next cycle with done=0; abort has priority over stall and completion.
REQ-029 start while busy SHALL be ignored; start and abort together in IDLE SHALL leave state IDLE.
REQ-030 Write in the same IDLE cycle as start SHALL take effect before the run reads that slot.

Reset
REQ-031 RST=1 SHALL force state IDLE, pc=0, iteration counter=0, ctx_valid=0, ctx_word=0, ctx_idx=0, busy=0, done=0, cfg_err=0.
REQ-032 Context store contents SHALL NOT be cleared by RST; RST mid-run SHALL abandon the run without done.

Structure
REQ-033 Shared package agu_pkg SHALL hold CTX_W, CTX_DEPTH, the state encoding, and the NOP opcode constant.
REQ-034 Context storage SHALL be a sub-module agu_ctx_mem (CTX_DEPTH x CTX_W register file, one write port, one async read port).

Verification
REQ-035 Load slots 0..2 with 0x0000101, 0x0000202, 0x0000301; start with ctx_last=2, iter_last=1 -> ctx_idx 0,1,2,0,1,2 on consecutive cycles, then done for one cycle, busy low after.
REQ-036 Same program, stall high for 3 cycles while ctx_idx=1 -> ctx_idx/ctx_word hold 3 cycles; done arrives exactly 3 cycles later than REQ-035.
REQ-037 cfg_we to slot 0 during RUN -> cfg_err pulse next cycle, slot 0 unchanged on next run.
REQ-038 abort asserted at ctx_idx=1 of first pass -> IDLE next cycle, ctx_valid=0, ctx_word=0, done never asserted.
REQ-039 RST asserted mid-run asynchronously -> all outputs zero immediately; a new start replays stored program unchanged.
REQ-040 ctx_last=0, iter_last=0 -> single cycle of slot 0 with ctx_valid=1, done next cycle.

Source files
------------

// File: rtl/agu_pkg.sv
// Shared definitions for the AGU context sequencer.
//   CTX_W     : width of one AGU configuration word
//   CTX_DEPTH : number of context slots
//   state_t   : sequencer state encoding
//   OP_NOP    : opcode presented to the AGU when no context is live
package agu_pkg;

   localparam int CTX_W     = 29;
   localparam int CTX_DEPTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [3:0] OP_NOP = 4'b0000;

endpackage

// File: rtl/agu_ctx_mem.sv
// Context store: CTX_DEPTH x CTX_W register file, one synchronous write
// port and one asynchronous read port. Contents are intentionally not
// reset so a programmed context survives a sequencer reset.
//   CLK   : clock
//   we    : write enable
//   waddr : write slot
//   wdata : write data
//   raddr : read slot
//   rdata : read data (combinational)
module agu_ctx_mem #(
   parameter int CTX_W     = agu_pkg::CTX_W,
   parameter int CTX_DEPTH = agu_pkg::CTX_DEPTH,
   parameter int AW        = $clog2(CTX_DEPTH)
) (
   input  logic             CLK,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [CTX_W-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [CTX_W-1:0] rdata
);

   logic [CTX_W-1:0] mem_q [CTX_DEPTH];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/agu_ctx_seq.sv
// AGU context sequencer: steps through a stored program of context words,
// presenting one per cycle to the AGU decode stage, repeated for a number
// of passes. The store is writable only while idle.
//   CLK, RST                          : clock, async active-high reset
//   cfg_we, cfg_addr, cfg_wdata       : context store write port
//   start, ctx_last, iter_last        : run request and program bounds
//   stall, abort                      : hold / terminate the current run
//   ctx_word, ctx_valid, ctx_idx      : presented context
//   busy, done, cfg_err               : status
//
// state | meaning
// IDLE  | store writable, waiting for start
// RUN   | presenting store[pc], advancing unless stalled
// FIN   | one-cycle completion, done asserted
module agu_ctx_seq #(
   parameter int CTX_W     = agu_pkg::CTX_W,
   parameter int CTX_DEPTH = agu_pkg::CTX_DEPTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_addr,
   input  logic [CTX_W-1:0] cfg_wdata,
   input  logic             start,
   input  logic [3:0]       ctx_last,
   input  logic [7:0]       iter_last,
   input  logic             stall,
   input  logic             abort,
   output logic [CTX_W-1:0] ctx_word,
   output logic             ctx_valid,
   output logic [3:0]       ctx_idx,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
);

   import agu_pkg::*;

   localparam logic [CTX_W-1:0] CTX_NOP = {OP_NOP, {(CTX_W-4){1'b0}}};

   state_t           state_q, state_d;
   logic [3:0]       pc_q, pc_d;
   logic [7:0]       iter_q, iter_d;
   logic [3:0]       ctx_last_q, ctx_last_d;
   logic [7:0]       iter_last_q, iter_last_d;
   logic             cfg_err_q, cfg_err_d;
   logic             mem_we;
   logic [CTX_W-1:0] mem_rdata;

   // Writes land at the clock edge that also takes a start, so the async
   // read in the first RUN cycle already sees the new word.
   assign mem_we    = cfg_we && (state_q == IDLE);
   assign cfg_err_d = cfg_we && (state_q != IDLE);

   agu_ctx_mem #(
      .CTX_W     (CTX_W),
      .CTX_DEPTH (CTX_DEPTH),
      .AW        (4)
   ) u_mem (
      .CLK   (CLK),
      .we    (mem_we),
      .waddr (cfg_addr),
      .wdata (cfg_wdata),
      .raddr (pc_q),
      .rdata (mem_rdata)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         iter_q      <= '0;
         ctx_last_q  <= '0;
         iter_last_q <= '0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         iter_q      <= iter_d;
         ctx_last_q  <= ctx_last_d;
         iter_last_q <= iter_last_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      iter_d      = iter_q;
      ctx_last_d  = ctx_last_q;
      iter_last_d = iter_last_q;
      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               ctx_last_d  = ctx_last;
               iter_last_d = iter_last;
               pc_d        = '0;
               iter_d      = '0;
               state_d     = RUN;
            end
         end
         RUN: begin
            // abort outranks both stall and completion
            if (abort) begin
               state_d = IDLE;
            end else if (!stall) begin
               if (pc_q == ctx_last_q) begin
                  // compare before increment so iter_last=255 never wraps
                  if (iter_q == iter_last_q) begin
                     state_d = FIN;
                  end else begin
                     pc_d   = '0;
                     iter_d = iter_q + 8'd1;
                  end
               end else begin
                  pc_d = pc_q + 4'd1;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ctx_valid = (state_q == RUN);
   assign ctx_word  = ctx_valid ? mem_rdata : CTX_NOP;
   assign ctx_idx   = ctx_valid ? pc_q : 4'd0;
   assign busy      = (state_q == RUN) || (state_q == FIN);
   assign done      = (state_q == FIN) && !abort;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_agu_ctx_seq.sv
module tb_agu_ctx_seq;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        cfg_we = 1'b0;
   logic [3:0]  cfg_addr = '0;
   logic [28:0] cfg_wdata = '0;
   logic        start = 1'b0;
   logic [3:0]  ctx_last = '0;
   logic [7:0]  iter_last = '0;
   logic        stall = 1'b0;
   logic        abort = 1'b0;
   logic [28:0] ctx_word;
   logic        ctx_valid;
   logic [3:0]  ctx_idx;
   logic        busy;
   logic        done;
   logic        cfg_err;

   agu_ctx_seq dut (
      .CLK       (CLK),
      .RST       (RST),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .start     (start),
      .ctx_last  (ctx_last),
      .iter_last (iter_last),
      .stall     (stall),
      .abort     (abort),
      .ctx_word  (ctx_word),
      .ctx_valid (ctx_valid),
      .ctx_idx   (ctx_idx),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit          is_done;
      logic [3:0]  idx;
      logic [28:0] word;
   } exp_t;

   exp_t        exp_q[$];
   logic [28:0] model_mem [16];
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Expected program trace: every pass visits slots 0..L in order, then one done.
   task automatic push_prog(input int L, input int I);
      exp_t e;
      for (int p = 0; p <= I; p++) begin
         for (int k = 0; k <= L; k++) begin
            e.is_done = 1'b0;
            e.idx     = 4'(k);
            e.word    = model_mem[k];
            exp_q.push_back(e);
         end
      end
      e.is_done = 1'b1;
      e.idx     = '0;
      e.word    = '0;
      exp_q.push_back(e);
   endtask

   // Monitor: a live context is consumed when it is not stalled or aborted.
   always @(negedge CLK) begin
      if (!RST) begin
         if (ctx_valid) begin
            if (exp_q.size() == 0) begin
               chk("valid_unexpected", ctx_valid, 1'b0);
            end else begin
               chk("ctx_is_done_slot", ctx_valid, exp_q[0].is_done ? 1'b0 : 1'b1);
               chk("ctx_idx", ctx_idx, exp_q[0].idx);
               chk("ctx_word", ctx_word, exp_q[0].word);
               if (!stall && !abort) void'(exp_q.pop_front());
            end
         end else begin
            chk("idle_word_nop", ctx_word, 29'd0);
            chk("idle_idx_zero", ctx_idx, 4'd0);
         end
         if (done) begin
            if (exp_q.size() == 0 || !exp_q[0].is_done) begin
               chk("done_unexpected", done, 1'b0);
            end else begin
               chk("done_with_busy", busy, 1'b1);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic wr(input int a, input logic [28:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = 4'(a);
      cfg_wdata = d;
      model_mem[a] = d;
      step();
      cfg_we = 1'b0;
   endtask

   // smode: 0 none, 1 random stall, 2 stall three cycles at first idx 1
   task automatic run_prog(input int L, input int I, input int smode, input int abort_idx,
                           input bit wr_start, input int wa, input logic [28:0] wd,
                           input bit wr_mid, input bit noise);
      int cyc = 0;
      int nstall = 0;
      int stalls1 = 0;
      int bound;
      bit got_done = 1'b0;
      bit aborted = 1'b0;
      bit abort_now;
      bound = (L + 1) * (I + 1) * 4 + 50;
      if (wr_start) begin
         cfg_we    = 1'b1;
         cfg_addr  = 4'(wa);
         cfg_wdata = wd;
         model_mem[wa] = wd;
      end
      start     = 1'b1;
      ctx_last  = 4'(L);
      iter_last = 8'(I);
      push_prog(L, I);
      step();
      start  = 1'b0;
      cfg_we = 1'b0;
      forever begin
         abort_now = 1'b0;
         stall     = 1'b0;
         if (smode == 1) stall = ($urandom % 4) == 0;
         if (smode == 2 && ctx_valid && ctx_idx == 4'd1 && stalls1 < 3) begin
            stall = 1'b1;
            stalls1++;
         end
         if (abort_idx >= 0 && !aborted && ctx_valid && ctx_idx == 4'(abort_idx)) begin
            abort     = 1'b1;
            abort_now = 1'b1;
            aborted   = 1'b1;
         end
         if (noise) begin
            start     = $urandom_range(0, 1) == 1;
            ctx_last  = 4'($urandom);
            iter_last = 8'($urandom);
         end
         if (wr_mid) begin
            cfg_we    = (cyc == 1);
            cfg_addr  = 4'd0;
            cfg_wdata = 29'($urandom);
         end
         @(negedge CLK);
         cyc++;
         if (wr_mid && cyc == 3) chk("cfg_err_pulse", cfg_err, 1'b1);
         if (wr_mid && cyc == 4) chk("cfg_err_clear", cfg_err, 1'b0);
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (stall) nstall++;
         if (abort_now) break;
         if (cyc > bound) begin
            chk("run_timeout", done, 1'b1);
            break;
         end
         step();
      end
      step();
      stall  = 1'b0;
      abort  = 1'b0;
      start  = 1'b0;
      cfg_we = 1'b0;
      if (aborted) exp_q.delete();
      @(negedge CLK);
      chk("after_busy", busy, 1'b0);
      chk("after_valid", ctx_valid, 1'b0);
      chk("after_word", ctx_word, 29'd0);
      chk("after_done", done, 1'b0);
      if (aborted) chk("abort_no_done", got_done, 1'b0);
      else chk("done_cycle", cyc, (L + 1) * (I + 1) + 1 + nstall);
      chk("queue_drained", exp_q.size(), 0);
      step();
   endtask

   initial begin
      #1 RST = 1'b1;
      #2;
      chk("rst_valid", ctx_valid, 1'b0);
      chk("rst_word", ctx_word, 29'd0);
      chk("rst_idx", ctx_idx, 4'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_cfg_err", cfg_err, 1'b0);
      step();
      RST = 1'b0;
      step();

      for (int k = 0; k < 16; k++) wr(k, 29'($urandom));
      wr(0, 29'h0000101);
      wr(1, 29'h0000202);
      wr(2, 29'h0000301);

      // basic program, then with a 3-cycle stall on idx 1
      run_prog(2, 1, 0, -1, 1'b0, 0, '0, 1'b0, 1'b0);
      run_prog(2, 1, 2, -1, 1'b0, 0, '0, 1'b0, 1'b0);
      // write during run rejected; replay proves slot 0 unchanged
      run_prog(2, 1, 0, -1, 1'b0, 0, '0, 1'b1, 1'b0);
      run_prog(2, 1, 0, -1, 1'b0, 0, '0, 1'b0, 1'b0);
      // abort on idx 1 of first pass
      run_prog(2, 1, 0, 1, 1'b0, 0, '0, 1'b0, 1'b0);

      // async reset mid-run
      start = 1'b1; ctx_last = 4'd2; iter_last = 8'd1;
      push_prog(2, 1);
      step();
      start = 1'b0;
      step();
      #2 RST = 1'b1;
      #1;
      chk("midrst_valid", ctx_valid, 1'b0);
      chk("midrst_word", ctx_word, 29'd0);
      chk("midrst_idx", ctx_idx, 4'd0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      exp_q.delete();
      step();
      RST = 1'b0;
      step();
      run_prog(2, 1, 0, -1, 1'b0, 0, '0, 1'b0, 1'b0);

      // single-slot single-pass, and 256 passes of slot 0
      run_prog(0, 0, 0, -1, 1'b0, 0, '0, 1'b0, 1'b0);
      run_prog(0, 255, 0, -1, 1'b0, 0, '0, 1'b0, 1'b0);
      // write in the start cycle
      run_prog(3, 0, 0, -1, 1'b1, 2, 29'($urandom), 1'b0, 1'b0);

      // start with abort in IDLE stays idle
      start = 1'b1; abort = 1'b1; ctx_last = 4'd2; iter_last = 8'd0;
      step();
      start = 1'b0; abort = 1'b0;
      @(negedge CLK);
      chk("start_abort_busy", busy, 1'b0);
      chk("start_abort_valid", ctx_valid, 1'b0);
      step();

      for (int r = 0; r < 30; r++) begin
         int L, I, ab;
         if ($urandom_range(0, 2) == 0) wr($urandom_range(0, 15), 29'($urandom));
         L  = $urandom_range(0, 15);
         I  = $urandom_range(0, 3);
         ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, L) : -1;
         run_prog(L, I, $urandom_range(0, 1), ab, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15), 29'($urandom), 1'b0, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
